ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs and computes the ALU result, branch target and destination register.
- Holds the EX/MEM pipeline register internally.
- Adds an iterative 32-cycle multiplier for R-type MUL (funct 0x18). While the multiplier runs, `stall` freezes PC, IF/ID and ID/EX, and a bubble is inserted into EX/MEM.

Parameters:
- DW, 32, datapath width (npc, operands, results)
- MUL_CYCLES, 32, shift-add iterations per multiply; must equal DW

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous; EX/MEM loads a bubble and the multiplier aborts
- npc  in  32  PC+4 from ID/EX
- rdata1  in  32  operand A
- rdata2  in  32  operand B / store data
- s_extend  in  32  sign-extended immediate; bits [5:0] are funct
- instr_2016  in  5  rt
- instr_1511  in  5  rd
- wb_ctl  in  2  WB controls {RegWrite, MemtoReg}
- m_ctl  in  3  MEM controls {Branch, MemRead, MemWrite}
- ex_ctl  in  4  {RegDst, ALUOp[1:0], ALUSrc}
- stall  out  1  combinational; hold upstream stages
- wb_ctlout  out  2  registered WB controls
- m_ctlout  out  3  registered MEM controls
- add_result  out  32  registered branch target
- zero  out  1  registered; alu_result == 0
- alu_result  out  32  registered ALU/MUL result
- rdata2out  out  32  registered store data
- muxout  out  5  registered destination register

Behaviour:
- Reset state: all registered outputs 0, multiplier FSM in IDLE, count 0. `stall` therefore evaluates to 0 unless the current inputs encode a MUL.
- Operand B is `s_extend` when ALUSrc=1, otherwise `rdata2`.
- ALU operation selected by ALUOp:
  - 00: add
  - 01: sub
  - 11: or
  - 10: decode funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0), 0x18 mul. Any other funct gives result 0.
- All arithmetic is modulo 2^32. No overflow trap.
- `add_result` = npc + (s_extend << 2), truncated to 32 bits.
- `muxout` = instr_1511 when RegDst=1, otherwise instr_2016.
- `is_mul` = (ALUOp==10 && funct==0x18).
- `stall` = is_mul && state != DONE.
- Multiplier FSM:
  - IDLE: if is_mul && !flush, latch multiplicand = A, multiplier = B, product = 0, count = 0, go to BUSY.
  - BUSY: each edge, if multiplier[0] then product += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. After iteration MUL_CYCLES-1, go to DONE.
  - DONE: single cycle. `stall` = 0; EX/MEM captures the product as `alu_result`; go to IDLE.
- Multiply result is the low 32 bits of the product, so it is sign-agnostic.
- Stall length: exactly 33 cycles (detect cycle + 32 BUSY cycles). The result is visible in EX/MEM one edge after the DONE cycle begins.
- EX/MEM load rules, per edge:
  - flush: wb_ctlout, m_ctlout, muxout = 0; other fields don't-care but cleared to 0.
  - else stall: same bubble as flush.
  - else: capture all computed values.
- Back-to-back MULs: after DONE, ID/EX advances. The next MUL is detected in IDLE the following cycle, giving another 33-cycle stall with no lost cycles.
- flush during BUSY or DONE: FSM returns to IDLE and EX/MEM takes a bubble. The product is discarded.
- reset mid-multiply: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared package:
  - ALUOp encodings
  - funct constants (ADD, SUB, AND, OR, SLT, MUL)
  - ALU operation enum
  - FSM state enum {IDLE, BUSY, DONE}
  - ex_ctl bit indices
- One sub-module, ex_mul_seq:
  - Interface: start, a, b → busy, done, product.
  - Contains the FSM and the counter, and takes clk, reset and flush.
- ALU decode and the mux logic stay in ex_stage.

Test Plan:
1. Reset asserted mid-cycle with non-zero inputs → all outputs 0 immediately; `stall` = 0 for non-MUL inputs.
2. R-type sub: ex_ctl=4'b1100, A=5, B=7, funct 0x22, rd=9 → next edge alu_result=0xFFFFFFFE, zero=0, muxout=9. Then slt with the same operands → alu_result=1.
3. beq-style: ALUOp=01, ALUSrc=0, A=B=0x1234, npc=0x100, s_extend=0xFFFFFFFF → zero=1, add_result=0xFC.
4. MUL: A=0xFFFFFFFF, B=3 → `stall` high for exactly 33 cycles and EX/MEM shows bubbles throughout; then alu_result=0xFFFFFFFD with wb_ctl propagated. A second MUL issued immediately afterwards → another 33-cycle stall.
5. flush asserted during BUSY cycle 10 of a MUL → `stall` drops the next cycle if the new ID/EX contents are not a MUL, EX/MEM holds a bubble, and no product is written.
6. lw-style: ALUSrc=1, RegDst=0, A=0x1000, imm=0xFFFFFFFC, rt=4 → alu_result=0xFFC, muxout=4, m_ctlout and rdata2out passed through unchanged.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALUOp/funct codes, ALU operation set,
// multiplier FSM states and ex_ctl bit positions.
package ex_stage_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MUL,
        ALU_NOP
    } alu_op_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    function automatic alu_op_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_t op;
        op = ALU_NOP;
        case (aluop)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_OR:  op = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: op = ALU_ADD;
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_SLT: op = ALU_SLT;
                    FUNCT_MUL: op = ALU_MUL;
                    default:   op = ALU_NOP;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one interface.
interface ex_stage_if #(parameter int DW = 32);
    logic          flush;
    logic [DW-1:0] npc;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] s_extend;
    logic [4:0]    instr_2016;
    logic [4:0]    instr_1511;
    logic [1:0]    wb_ctl;
    logic [2:0]    m_ctl;
    logic [3:0]    ex_ctl;
    logic          stall;
    logic [1:0]    wb_ctlout;
    logic [2:0]    m_ctlout;
    logic [DW-1:0] add_result;
    logic          zero;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] rdata2out;
    logic [4:0]    muxout;

    modport master (
        output flush, npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
               wb_ctl, m_ctl, ex_ctl,
        input  stall, wb_ctlout, m_ctlout, add_result, zero, alu_result,
               rdata2out, muxout
    );

    modport slave (
        input  flush, npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
               wb_ctl, m_ctl, ex_ctl,
        output stall, wb_ctlout, m_ctlout, add_result, zero, alu_result,
               rdata2out, muxout
    );
endinterface

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier, one partial product per clock.
//   state | meaning
//   IDLE  | waiting for start; product register holds last result
//   BUSY  | MUL_CYCLES shift-add iterations, count tracks the iteration
//   DONE  | one cycle; product is final and consumed by EX/MEM
module ex_mul_seq
    import ex_stage_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product
);
    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        prod   <= '0;
                        count  <= '0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state == ST_BUSY);
    assign done    = (state == ST_DONE);
    assign product = prod;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, destination select and the EX/MEM register,
// with an iterative multiplier that stalls upstream stages while it runs.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MUL_CYCLES = 32
) (
    input logic     clk,
    input logic     reset,
    ex_stage_if.slave bus
);
    logic [1:0]    aluop;
    logic [5:0]    funct;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    alu_op_t       op;
    logic          is_mul;
    logic          lt;
    logic [DW-1:0] alu_val;
    logic [DW-1:0] branch_tgt;
    logic [4:0]    dest;
    logic          mul_busy;
    logic          mul_done;
    logic [DW-1:0] mul_product;
    logic          bubble;

    assign aluop      = bus.ex_ctl[EX_ALUOP_HI:EX_ALUOP_LO];
    assign funct      = bus.s_extend[5:0];
    assign op_a       = bus.rdata1;
    assign op_b       = bus.ex_ctl[EX_ALUSRC] ? bus.s_extend : bus.rdata2;
    assign op         = alu_decode(aluop, funct);
    assign is_mul     = (aluop == ALUOP_FUNCT) && (funct == FUNCT_MUL);
    assign lt         = $signed(op_a) < $signed(op_b);
    assign branch_tgt = bus.npc + {bus.s_extend[DW-3:0], 2'b00};
    assign dest       = bus.ex_ctl[EX_REGDST] ? bus.instr_1511 : bus.instr_2016;

    always_comb begin
        alu_val = '0;
        case (op)
            ALU_ADD: alu_val = op_a + op_b;
            ALU_SUB: alu_val = op_a - op_b;
            ALU_AND: alu_val = op_a & op_b;
            ALU_OR:  alu_val = op_a | op_b;
            ALU_SLT: alu_val = {{(DW-1){1'b0}}, lt};
            ALU_MUL: alu_val = mul_product;
            default: alu_val = '0;
        endcase
    end

    ex_mul_seq #(
        .DW         (DW),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.flush),
        .start   (is_mul),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign bus.stall = is_mul && !mul_done;

    // A partial product must never reach EX/MEM, even if ID/EX changed under a running multiply.
    assign bubble = bus.flush || bus.stall || mul_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || bubble) begin
            bus.wb_ctlout  <= '0;
            bus.m_ctlout   <= '0;
            bus.add_result <= '0;
            bus.zero       <= 1'b0;
            bus.alu_result <= '0;
            bus.rdata2out  <= '0;
            bus.muxout     <= '0;
        end else begin
            bus.wb_ctlout  <= bus.wb_ctl;
            bus.m_ctlout   <= bus.m_ctl;
            bus.add_result <= branch_tgt;
            bus.zero       <= (alu_val == '0);
            bus.alu_result <= alu_val;
            bus.rdata2out  <= bus.rdata2;
            bus.muxout     <= dest;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver queues the expected EX/MEM contents per
// cycle, an independent monitor pops and compares after each clock edge.
module tb_ex_stage;
    logic clk;
    logic reset;
    ex_stage_if #(.DW(32)) bus ();

    ex_stage #(.DW(32), .MUL_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] npc, a, b, sx;
        logic [4:0]  rt, rd;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
    } stim_t;

    typedef struct {
        int          id;
        logic        stall;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  mux;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, id, act, req);
        end
    endtask

    function automatic stim_t mk(input logic [31:0] npc, a, b, sx, input logic [4:0] rt, rd,
                                 input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex);
        stim_t s;
        s.npc = npc; s.a = a; s.b = b; s.sx = sx; s.rt = rt; s.rd = rd;
        s.wb = wb; s.m = m; s.ex = ex;
        return s;
    endfunction

    function automatic exp_t cap(input int id, input stim_t s, input logic [31:0] alu,
                                 input logic [31:0] add, input logic [4:0] mux);
        exp_t e;
        e.id = id; e.stall = 1'b0; e.wb = s.wb; e.m = s.m; e.add = add;
        e.zero = (alu == 32'h0); e.alu = alu; e.rd2 = s.b; e.mux = mux;
        return e;
    endfunction

    function automatic exp_t bub(input int id, input logic st);
        exp_t e;
        e.id = id; e.stall = st; e.wb = '0; e.m = '0; e.add = '0;
        e.zero = 1'b0; e.alu = '0; e.rd2 = '0; e.mux = '0;
        return e;
    endfunction

    task automatic apply(input stim_t s, input logic fl);
        bus.npc = s.npc; bus.rdata1 = s.a; bus.rdata2 = s.b; bus.s_extend = s.sx;
        bus.instr_2016 = s.rt; bus.instr_1511 = s.rd; bus.wb_ctl = s.wb;
        bus.m_ctl = s.m; bus.ex_ctl = s.ex; bus.flush = fl;
    endtask

    // Called at a falling edge; drives one ID/EX cycle and queues what EX/MEM must show after it.
    task automatic issue(input stim_t s, input logic fl, input exp_t e);
        apply(s, fl);
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic mul_run(input int id, input stim_t s, input logic [31:0] prod, input logic [31:0] add);
        for (int i = 0; i < 33; i++) issue(s, 1'b0, bub(id, 1'b1));
        issue(s, 1'b0, cap(id, s, prod, add, s.rd));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sbq.size());
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wb"},   0, 32'(bus.wb_ctlout),  32'h0);
        chk({tag, "_m"},    0, 32'(bus.m_ctlout),   32'h0);
        chk({tag, "_add"},  0, bus.add_result,      32'h0);
        chk({tag, "_zero"}, 0, 32'(bus.zero),       32'h0);
        chk({tag, "_alu"},  0, bus.alu_result,      32'h0);
        chk({tag, "_rd2"},  0, bus.rdata2out,       32'h0);
        chk({tag, "_mux"},  0, 32'(bus.muxout),     32'h0);
    endtask

    // Monitor: stall is sampled mid-cycle, EX/MEM just after the rising edge.
    initial begin
        logic st;
        forever begin
            @(negedge clk);
            #2 st = bus.stall;
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("stall",      e.id, 32'(st),             32'(e.stall));
                chk("wb_ctlout",  e.id, 32'(bus.wb_ctlout),  32'(e.wb));
                chk("m_ctlout",   e.id, 32'(bus.m_ctlout),   32'(e.m));
                chk("add_result", e.id, bus.add_result,      e.add);
                chk("zero",       e.id, 32'(bus.zero),       32'(e.zero));
                chk("alu_result", e.id, bus.alu_result,      e.alu);
                chk("rdata2out",  e.id, bus.rdata2out,       e.rd2);
                chk("muxout",     e.id, 32'(bus.muxout),     32'(e.mux));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        stim_t v_sub, v_slt, v_and, v_bad, v_beq, v_lw, v_ori, m1, m2, mf, m3;
        v_sub = mk(32'h40, 32'd5, 32'd7, 32'h22, 5'd3, 5'd9, 2'b10, 3'b000, 4'b1100);
        v_slt = mk(32'h40, 32'd5, 32'd7, 32'h2A, 5'd3, 5'd9, 2'b10, 3'b000, 4'b1100);
        v_and = mk(32'h40, 32'hF0F0, 32'h0FF0, 32'h24, 5'd3, 5'd9, 2'b10, 3'b000, 4'b1100);
        v_bad = mk(32'h40, 32'd5, 32'd7, 32'h27, 5'd3, 5'd9, 2'b10, 3'b000, 4'b1100);
        v_beq = mk(32'h100, 32'h1234, 32'h1234, 32'hFFFFFFFF, 5'd5, 5'd6, 2'b00, 3'b100, 4'b0010);
        v_lw  = mk(32'h200, 32'h1000, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd4, 5'd7, 2'b11, 3'b010, 4'b0001);
        v_ori = mk(32'h300, 32'h00FF0000, 32'h5, 32'h1234, 5'd8, 5'd1, 2'b10, 3'b000, 4'b0111);
        m1 = mk(32'h400, 32'hFFFFFFFF, 32'd3, 32'h18, 5'd2, 5'd10, 2'b10, 3'b000, 4'b1100);
        m2 = mk(32'h404, 32'h80000000, 32'd2, 32'h18, 5'd2, 5'd11, 2'b10, 3'b000, 4'b1100);
        mf = mk(32'h480, 32'd9, 32'd9, 32'h18, 5'd2, 5'd12, 2'b10, 3'b000, 4'b1100);
        m3 = mk(32'h500, 32'd3, 32'h80000001, 32'h18, 5'd2, 5'd13, 2'b10, 3'b000, 4'b1100);

        reset = 1'b1;
        apply(v_sub, 1'b0);
        repeat (2) @(negedge clk);
        chk_zero("por");
        reset = 1'b0;

        issue(v_sub, 1'b0, cap(1, v_sub, 32'hFFFFFFFE, 32'hC8, 5'd9));
        drain();
        // Mid-cycle reset with a live, non-MUL instruction on the inputs.
        #2 reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        chk("rst_stall", 0, 32'(bus.stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        issue(v_sub, 1'b0, cap(2, v_sub, 32'hFFFFFFFE, 32'hC8, 5'd9));
        issue(v_slt, 1'b0, cap(3, v_slt, 32'h1, 32'hE8, 5'd9));
        issue(v_and, 1'b0, cap(4, v_and, 32'hF0, 32'hD0, 5'd9));
        issue(v_bad, 1'b0, cap(5, v_bad, 32'h0, 32'hDC, 5'd9));
        issue(v_beq, 1'b0, cap(6, v_beq, 32'h0, 32'hFC, 5'd5));
        issue(v_lw,  1'b0, cap(7, v_lw, 32'hFFC, 32'h1F0, 5'd4));
        issue(v_ori, 1'b0, cap(8, v_ori, 32'h00FF1234, 32'h4BD0, 5'd8));
        issue(v_sub, 1'b1, bub(9, 1'b0));

        mul_run(10, m1, 32'hFFFFFFFD, 32'h460);
        mul_run(11, m2, 32'h0, 32'h464);

        for (int i = 0; i < 10; i++) issue(mf, 1'b0, bub(12, 1'b1));
        issue(mf, 1'b1, bub(13, 1'b1));
        issue(v_sub, 1'b0, cap(14, v_sub, 32'hFFFFFFFE, 32'hC8, 5'd9));

        mul_run(15, m3, 32'h80000003, 32'h560);
        drain();

        for (int i = 0; i < 5; i++) issue(m3, 1'b0, bub(16, 1'b1));
        drain();
        #2 reset = 1'b1;
        #1;
        chk_zero("rst_mul");
        chk("rst_mul_stall", 0, 32'(bus.stall), 32'h1);
        apply(v_sub, 1'b0);
        #1 chk("rst_nonmul_stall", 0, 32'(bus.stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        issue(v_lw, 1'b0, cap(17, v_lw, 32'hFFC, 32'h1F0, 5'd4));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
